// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order decoupling queue between the fetch unit and decode. It stores
//   {pc, instr} pairs in a DEPTH-entry register array and uses valid/ready on
//   both sides. flush drops every queued (wrong-path) entry.
//
//   Optional build macro: FETCH_QUEUE_BYPASS_EN. When it is defined and the
//   queue is empty, the input pair is forwarded combinationally to the head.
//
// Ports
//   clk        system clock (rising edge)
//   reset      synchronous, active-low clear
//   flush      redirect; the queue is empty after the next edge
//   in_valid   fetch presents a pair
//   in_ready   queue has room (depends on state only)
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   out_valid  head entry valid
//   out_ready  decode consumes the head
//   out_pc     head PC (0 when not valid)
//   out_pc8    out_pc + 8, the link address
//   out_instr  head instruction (0 / NOP when not valid)
//   count      occupied entries, 0..DEPTH
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc8,
  output logic [31:0]   out_instr,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;

  logic [63:0]   head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass_take;
  logic          wr_en;

  // RESET_PC is informational only (the expected first PC for a bench).
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  always_comb begin
    empty     = (count_q == '0);
    in_ready  = (count_q != FULL_CNT);
    head      = mem_q[rp_q];

    out_valid = !empty;
    out_pc    = empty ? 32'd0 : head[63:32];
    out_instr = empty ? 32'd0 : head[31:0];
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming pair directly at the head.
    if (empty && !flush) begin
      out_valid = in_valid;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
    out_pc8 = out_pc + 32'd8;

    push = in_valid & in_ready;
    pop  = out_valid & out_ready;

    bypass_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Pair forwarded and consumed in the same cycle never touches the array.
    bypass_take = empty & push & pop;
`endif

    wr_en = push & !bypass_take & !flush & reset;

    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else if (!bypass_take) begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Array contents need no reset; the occupancy count qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= {in_pc, in_instr};
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed plus random stimulus against a queue-based reference model of
//   the fetch queue. Outputs are sampled on the falling clock edge.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [31:0]   in_pc, in_instr;
  logic          in_ready, out_valid;
  logic [31:0]   out_pc, out_pc8, out_instr;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  logic [63:0] q[$];
  logic [31:0] last_pc;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc8(out_pc8), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input logic rst_n, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    int          sz;
    logic        ev;
    logic [31:0] epc, eins;
    logic        psh, pp;
    reset = rst_n; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    @(negedge clk);
    sz = q.size();
    ev = 1'b0; epc = 32'd0; eins = 32'd0;
    if (sz != 0) begin
      ev = 1'b1; epc = q[0][63:32]; eins = q[0][31:0];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (!fl) begin
      ev = iv; epc = iv ? pc : 32'd0; eins = iv ? ins : 32'd0;
      if (iv) begin epc = pc; eins = ins; end
      epc = pc; eins = ins;
    end
`endif
    if (armed) begin
      chk("count",     32'(count),     32'(sz));
      chk("in_ready",  32'(in_ready),  32'(sz != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_pc",    out_pc,         epc);
      chk("out_instr", out_instr,      eins);
      chk("out_pc8",   out_pc8,        epc + 32'd8);
    end
    last_pc = out_pc;
    @(posedge clk);
    if (!rst_n || fl) begin
      q.delete();
    end else begin
      psh = iv && (sz < DEPTH);
      pp  = ev && ordy;
      if (!(sz == 0 && psh && pp)) begin
        if (pp)  void'(q.pop_front());
        if (psh) q.push_back({pc, ins});
      end
    end
    armed = 1;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc_n;
    logic [31:0] prev;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0; last_pc = 32'd0;
    @(posedge clk); #1;

    // Reset held for two cycles, then idle.
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle();
    chk("rst_count",  32'(count),    32'd0);
    chk("rst_ready",  32'(in_ready), 32'd1);

    // Fill to full with out_ready low, then a fifth push that must be ignored.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, RESET_PC + 32'(4*i), $urandom, 1'b0);
    chk("full_count", 32'(count),    32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h3010, $urandom, 1'b0);
    chk("full_head",  out_pc,  32'h3000);
    chk("full_pc8",   out_pc8, 32'h3008);

    // Pop at full while in_valid is high.
    step(1'b1, 1'b0, 1'b1, 32'h3010, $urandom, 1'b1);
    chk("popfull_count", 32'(count), 32'd3);
    chk("popfull_head",  out_pc,     32'h3004);
    chk("popfull_ready", 32'(in_ready), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h3010, $urandom, 1'b0);
    chk("refill_count", 32'(count), 32'd4);

    // Drain to two entries, then stream push+pop for 10 cycles across the wrap.
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("stream_start", 32'(count), 32'd2);
    pc_n = 32'h3014;
    prev = 32'h3008;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, pc_n, $urandom, 1'b1);
      chk("stream_order", last_pc, prev + 32'd4);
      chk("stream_count", 32'(count), 32'd2);
      prev  = last_pc;
      pc_n += 32'd4;
    end

    // Flush with concurrent push and pop at count=3.
    step(1'b1, 1'b0, 1'b1, pc_n, $urandom, 1'b0);
    chk("preflush_count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 32'h4000, $urandom, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h4000, 32'h0000_0013, 1'b0);
    chk("postflush_head", out_pc, 32'h4000);
    chk("postflush_cnt",  32'(count), 32'd1);

    // Empty pop, then reset with a concurrent push at count=2.
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("emptypop_count", 32'(count), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h5000, $urandom, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h5004, $urandom, 1'b0);
    chk("prerst_count", 32'(count), 32'd2);
    step(1'b0, 1'b0, 1'b1, 32'h5008, $urandom, 1'b0);
    chk("midrst_count", 32'(count), 32'd0);
    idle();

    // Bypass-or-not empty push with out_ready high; the model covers both builds.
    step(1'b1, 1'b0, 1'b1, 32'h6000, $urandom, 1'b1);
    idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
           $urandom, $urandom,
           ($urandom_range(99) < 55) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
